// File: rtl/growth_pkg.sv
// Shared perspective growth-rate table: one source of truth for the forward
// depth-to-rate lookup and the inverse rate-to-depth search.
package growth_pkg;

   localparam int NBANDS   = 16;
   localparam int IDX_W    = 4;
   localparam int RATE_W   = 7;
   localparam int DEPTH_W  = 13;
   localparam int MAX_RATE = 127;

   typedef logic [DEPTH_W-1:0] depth_t;
   typedef logic [RATE_W-1:0]  rate_t;

   // Band 0 is the nearest band; depth decreases and rate grows with the index.
   localparam depth_t BAND_UPPER [NBANDS] = '{
      13'd8064, 13'd8026, 13'd7976, 13'd7912, 13'd7829, 13'd7722, 13'd7583, 13'd7402,
      13'd7168, 13'd6856, 13'd6466, 13'd5958, 13'd5295, 13'd4435, 13'd3321, 13'd1875
   };

   localparam rate_t BAND_RATE [NBANDS] = '{
      7'd2,  7'd3,  7'd4,  7'd5,  7'd7,  7'd9,  7'd12, 7'd16,
      7'd20, 7'd26, 7'd34, 7'd45, 7'd58, 7'd76, 7'd98, 7'd127
   };

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DONE
   } state_e;

endpackage

// File: rtl/growth_band_rom.sv
// Combinational band lookup: index -> inclusive depth range and growth rate.
module growth_band_rom
   import growth_pkg::*;
#(
   parameter int DW = DEPTH_W
) (
   input  logic [IDX_W-1:0]  idx,
   output logic [DW-1:0]     upper,
   output logic [DW-1:0]     lower,
   output logic [RATE_W-1:0] rate
);

   always_comb begin
      upper = DW'(BAND_UPPER[idx]);
      rate  = BAND_RATE[idx];
      // The farthest band has no neighbour beyond it, so it extends down to depth 1.
      if (idx == IDX_W'(NBANDS - 1))
         lower = DW'(1);
      else
         lower = DW'(BAND_UPPER[idx + IDX_W'(1)]) + DW'(1);
   end

endmodule

// File: rtl/growth_depth_search.sv
// Inverse growth-rate lookup: scans the shared bands for the nearest band whose
// rate reaches the requested rate and returns that band's depth range.
module growth_depth_search
   import growth_pkg::*;
#(
   parameter int DW = DEPTH_W
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [DW-1:0] req_grate,
   output logic          resp_valid,
   input  logic          resp_ready,
   output logic [DW-1:0] depth_hi,
   output logic [DW-1:0] depth_lo,
   output logic [3:0]    band,
   output logic          sat
);

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DW-1:0]     req_q, req_d;
   logic              req_ready_q, req_ready_d;
   logic              resp_valid_q, resp_valid_d;
   logic [DW-1:0]     depth_hi_q, depth_hi_d;
   logic [DW-1:0]     depth_lo_q, depth_lo_d;
   logic [3:0]        band_q, band_d;
   logic              sat_q, sat_d;

   logic [DW-1:0]     rom_upper, rom_lower;
   logic [RATE_W-1:0] rom_rate;
   logic              hit;

   growth_band_rom #(.DW(DW)) u_rom (
      .idx   (idx_q),
      .upper (rom_upper),
      .lower (rom_lower),
      .rate  (rom_rate)
   );

   assign hit = (DW'(rom_rate) >= req_q);

   always_comb begin
      // NOTE: every _d starts as its _q so no path through the case infers a latch.
      state_d      = state_q;
      idx_d        = idx_q;
      req_d        = req_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = resp_valid_q;
      depth_hi_d   = depth_hi_q;
      depth_lo_d   = depth_lo_q;
      band_d       = band_q;
      sat_d        = sat_q;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready_q) begin
               req_d       = req_grate;
               idx_d       = '0;
               req_ready_d = 1'b0;
               state_d     = ST_SCAN;
            end
         end
         ST_SCAN: begin
            // Reaching the last band without a hit means the request saturates.
            if (hit || idx_q == IDX_W'(NBANDS - 1)) begin
               depth_hi_d   = rom_upper;
               depth_lo_d   = rom_lower;
               band_d       = idx_q;
               sat_d        = ~hit;
               resp_valid_d = 1'b1;
               state_d      = ST_DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         ST_DONE: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               req_ready_d  = 1'b1;
               state_d      = ST_IDLE;
            end
         end
         default: begin
            req_ready_d = 1'b1;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignment only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         req_q        <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         depth_hi_q   <= '0;
         depth_lo_q   <= '0;
         band_q       <= '0;
         sat_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         req_q        <= req_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         depth_hi_q   <= depth_hi_d;
         depth_lo_q   <= depth_lo_d;
         band_q       <= band_d;
         sat_q        <= sat_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign depth_hi   = depth_hi_q;
   assign depth_lo   = depth_lo_q;
   assign band       = band_q;
   assign sat        = sat_q;

endmodule

// File: doc/growth_depth_search.md
Name: growth_depth_search

Overview:
Inverse of the perspective growth-rate table. Takes a requested growth rate (size scale) and returns the depth band that produces it, so a spawner can place an object at a target on-screen size. The block does a sequential scan over the 16 shared depth bands, with valid/ready handshakes on both sides. It sits between game-logic object placement and the depth register file.

Parameters:
DW, 13, depth and rate bus width (matches the forward table's depth/grate width)
NBANDS, 16, number of depth bands (fixed by the shared table)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block idle, can accept
req_grate  in  DW  requested growth rate, unsigned; values above 127 saturate
resp_valid  out  1  result valid, held until taken
resp_ready  in  1  consumer takes result
depth_hi  out  DW  inclusive upper depth bound of the matched band
depth_lo  out  DW  inclusive lower depth bound of the matched band
band  out  4  matched band index, 0 = nearest (rate 2)
sat  out  1  request exceeded the maximum rate 127

Behaviour:
- Band table, k = 0..15. Rate R: 2,3,4,5,7,9,12,16,20,26,34,45,58,76,98,127.
- Upper bound U: 8064,8026,7976,7912,7829,7722,7583,7402,7168,6856,6466,5958,5295,4435,3321,1875.
- Lower bound: lo_k = U_(k+1)+1, and lo_15 = 1. All comparisons are unsigned DW-bit.
- Match rule: the smallest k with R_k >= req_grate. Outputs are depth_hi=U_k, depth_lo=lo_k, band=k.
- No match (req_grate > 127): result is band 15 with sat=1.
- req_grate 0 or 1: band 0.
- FSM states:
  - IDLE: req_ready=1. On req_valid&req_ready, capture req_grate, set idx=0, and go to SCAN.
  - SCAN: each cycle compare R_idx against the captured request.
    - On hit, or at idx=15, register the outputs, set resp_valid=1, and go to DONE.
    - Otherwise idx++.
  - DONE: hold all outputs stable. When resp_valid&resp_ready, clear resp_valid and go to IDLE.
- req_ready is 0 in SCAN and DONE. req_valid is ignored outside IDLE.
- Latency: for an accept at edge N and a match at band k, resp_valid rises at edge N+k+1. The range is 1..16 cycles.
- Throughput: one request in flight. The earliest next accept is the cycle after the response handshake.
- Reset (async, any time, including mid-scan): state=IDLE, idx=0, resp_valid=0, req_ready=1, depth_hi=0, depth_lo=0, band=0, sat=0.
- Outputs only change on the SCAN->DONE transition or on reset.

Decomposition:
- Package growth_pkg holds:
  - NBANDS, RATE_W=7, MAX_RATE=127.
  - Constant arrays BAND_UPPER[16], BAND_RATE[16].
  - The FSM state enum.
- growth_pkg is shared with the forward depth-to-rate table so both directions use one source of truth.
- Sub-module growth_band_rom: combinational idx[3:0] -> U, lo, R. It is instantiated once here, and the forward table can reuse it.

Test Plan:
1. Reset, then req_grate=2 -> resp_valid at accept+1, band=0, depth_hi=8064, depth_lo=8027, sat=0.
2. req_grate=10 -> band=6 (rate 12), depth_hi=7583, depth_lo=7403, latency 7 cycles, sat=0.
3. req_grate=127 -> band=15, depth_hi=1875, depth_lo=1, latency 16, sat=0. Then req_grate=200 -> band=15, sat=1, latency 16. Then req_grate=0 -> band=0.
4. Backpressure: hold resp_ready=0 for 5 cycles with req_valid=1 and new data.
   - Outputs stay stable and req_ready=0; the second request is not accepted.
   - It is accepted the cycle after resp_ready=1.
5. Assert reset at SCAN idx=4 -> all outputs return to reset values immediately, req_ready=1. A following request completes normally.
6. Sweep req_grate 0..140.
   - Feed depth_hi and depth_lo into the forward table: both return R_band, and R_band >= req_grate.
   - R_(band-1) < req_grate whenever band > 0 and sat=0.
